writeback_stage: RTL
====================

# writeback_stage

Final pipeline stage, directly downstream of the memory-stage handler. Captures the memory-stage result when `memory_done` is raised, formats load data (byte/half/word/double extraction with sign or zero extension), selects the register-file write value, and issues a single-cycle register-file write. Drives `mem_wb_pipeline_valid` back to the memory handler to close the done/valid handshake, and counts retired instructions.

## Interface
- `XLEN`, 64, datapath width
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `memory_done`  in  1  memory-stage result ready
- `loaded_data_out`  in  64  raw aligned doubleword from the memory stage
- `alu_data`  in  64  ALU result; bits [2:0] are the load byte offset
- `pc_plus_4`  in  64  link value for jumps
- `rd`  in  5  destination register
- `reg_write`, `mem_to_reg`, `is_jump`, `load_unsigned`  in  1 each  control
- `load_size`  in  2  0=byte, 1=half, 2=word, 3=double
- `mem_wb_pipeline_valid`  out  1  latched result held (handshake to memory stage)
- `rf_write_enable`  out  1  register-file write strobe
- `rf_write_addr`  out  5  write address
- `rf_write_data`  out  64  write data
- `wb_done`  out  1  one-cycle retire pulse
- `misaligned_fault`  out  1  one-cycle pulse, misaligned load detected
- `retired_count`  out  64  instructions retired since reset

## Operation
- State machine: IDLE, WRITE, RELEASE. All outputs registered.
- IDLE: `mem_wb_pipeline_valid`=0. On edge with `memory_done`=1: capture all inputs, compute write data, go to WRITE.
- WRITE (exactly one cycle): `mem_wb_pipeline_valid`=1, `wb_done`=1, `rf_write_enable`=1 iff `reg_write` && `rd`!=0 && no fault. Next state RELEASE.
- RELEASE: `mem_wb_pipeline_valid`=1, strobes 0. When `memory_done` sampled 0, go to IDLE (valid clears that edge). While `memory_done` stays 1, remain.
- Write data: `is_jump` → `pc_plus_4`; else `mem_to_reg` → formatted load; else `alu_data`.
- Load format, offset o = `alu_data[2:0]`: byte = data[8o+7:8o]; half = data[8o+15:8o]; word = data[8o+31:8o]; double = full data. Sign-extend from MSB of the field unless `load_unsigned`; double ignores `load_unsigned`.
- Misaligned when `mem_to_reg`: half with o[0]=1; word with o[1:0]!=0; double with o!=0. Then `misaligned_fault` pulses in WRITE, no RF write, `wb_done` still pulses.
- `retired_count` increments by 1 on entry to WRITE (visible from the WRITE cycle), wraps at 2^64-1 → 0.
- `rf_write_addr`/`rf_write_data` hold last captured values outside WRITE.

## Timing
- Reset (async, any state): state IDLE; every output 0 including `retired_count`; an in-flight capture is discarded, no write issued.
- Latency: `memory_done` high at edge N → `rf_write_enable`/`wb_done`/valid high during cycle N+1.
- Minimum occupancy 2 cycles (WRITE + one RELEASE); back-to-back results accepted no sooner than every 3 cycles.
- `memory_done` high in RELEASE is never treated as a new result; a new capture requires passing through IDLE.
- `memory_done` re-asserted in the same cycle RELEASE exits to IDLE is captured on the following IDLE edge.
- Non-memory instructions (memory stage holds `memory_done`=1 steadily) still retire once per valid 0→1→0 cycle.

## Test plan
- Reset mid-WRITE: assert `reset` asynchronously between edges → all outputs 0 immediately, no write, `retired_count`=0.
- Signed byte load: data=0x00000000_0000_80_00 style value 0x0000_0000_0000_8000, o=1, size 0, signed → `rf_write_data`=0xFFFF_FFFF_FFFF_FF80, rd=5, one write pulse at N+1.
- Unsigned word load: data=0xDEADBEEF_12345678, o=4, size 2, unsigned → 0x0000_0000_DEAD_BEEF.
- Misaligned half: o=3, size 1, `mem_to_reg`=1 → `misaligned_fault`=1 one cycle, `rf_write_enable`=0, `wb_done`=1, count +1.
- Jump with rd=0: `is_jump`=1, `pc_plus_4`=0x1004 → no RF write; with rd=1 → write 0x1004.
- Handshake: hold `memory_done` high 4 cycles after valid rises → valid stays high, single write, single count increment; drop done → valid low next edge; 10 back-to-back results → `retired_count`=10.

Source files
------------

// File: rtl/writeback_stage.sv
// Final pipeline stage: captures the memory-stage result, formats load data,
// and issues a single-cycle register-file write with a done/valid handshake.
module writeback_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            memory_done,
    input  logic [XLEN-1:0] loaded_data_out,
    input  logic [XLEN-1:0] alu_data,
    input  logic [XLEN-1:0] pc_plus_4,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    input  logic            mem_to_reg,
    input  logic            is_jump,
    input  logic            load_unsigned,
    input  logic [1:0]      load_size,
    output logic            mem_wb_pipeline_valid,
    output logic            rf_write_enable,
    output logic [4:0]      rf_write_addr,
    output logic [XLEN-1:0] rf_write_data,
    output logic            wb_done,
    output logic            misaligned_fault,
    output logic [XLEN-1:0] retired_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [XLEN-1:0] CNT_ONE = {{(XLEN-1){1'b0}}, 1'b1};

    // Extract the addressed field and extend it; double ignores load_unsigned.
    function automatic logic [XLEN-1:0] format_load(
        input logic [XLEN-1:0] raw,
        input logic [2:0]      off,
        input logic [1:0]      size,
        input logic            uns
    );
        logic [XLEN-1:0] sh;
        sh = raw >> {off, 3'b000};
        case (size)
            2'd0:    format_load = uns ? {{(XLEN-8){1'b0}}, sh[7:0]}
                                       : {{(XLEN-8){sh[7]}}, sh[7:0]};
            2'd1:    format_load = uns ? {{(XLEN-16){1'b0}}, sh[15:0]}
                                       : {{(XLEN-16){sh[15]}}, sh[15:0]};
            2'd2:    format_load = uns ? {{(XLEN-32){1'b0}}, sh[31:0]}
                                       : {{(XLEN-32){sh[31]}}, sh[31:0]};
            default: format_load = raw;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
        case (size)
            2'd0:    is_misaligned = 1'b0;
            2'd1:    is_misaligned = off[0];
            2'd2:    is_misaligned = (off[1:0] != 2'd0);
            default: is_misaligned = (off != 3'd0);
        endcase
    endfunction

    logic [1:0]      state_q, state_d;
    logic            valid_q, valid_d;
    logic            we_q, we_d;
    logic [4:0]      addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            done_q, done_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] count_q, count_d;
    logic            fault_s;

    assign fault_s = mem_to_reg && is_misaligned(alu_data[2:0], load_size);

    // Next-state and next-output computation for the writeback FSM.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (memory_done) begin
                    state_d = ST_WRITE;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    fault_d = fault_s;
                    we_d    = reg_write && (rd != 5'd0) && !fault_s;
                    addr_d  = rd;
                    count_d = count_q + CNT_ONE;
                    if (is_jump) begin
                        data_d = pc_plus_4;
                    end else if (mem_to_reg) begin
                        data_d = format_load(loaded_data_out, alu_data[2:0],
                                             load_size, load_unsigned);
                    end else begin
                        data_d = alu_data;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                valid_d = 1'b1;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // A held memory_done here is the old result, never a new one.
                if (!memory_done) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 5'd0;
            data_q  <= {XLEN{1'b0}};
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            count_q <= {XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign mem_wb_pipeline_valid = valid_q;
    assign rf_write_enable       = we_q;
    assign rf_write_addr         = addr_q;
    assign rf_write_data         = data_q;
    assign wb_done               = done_q;
    assign misaligned_fault      = fault_q;
    assign retired_count         = count_q;

endmodule
